// File: rtl/morse_pkg.sv
// Shared Morse definitions: symbol codes, encoder state enum, ASCII-to-pattern table.
// Pattern format: four 2-bit symbols, MSB pair sent first, leading empty pairs skipped.
// Pure definitions, no timing or flow control.
package morse_pkg;

  localparam logic [1:0] SYM_NONE = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_SYM_GAP,
    ST_CHAR_GAP,
    ST_WORD_GAP,
    ST_ERR
  } state_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] pat;
  } lut_t;

  // Letters are case-folded; space is valid with an all-empty pattern.
  function automatic lut_t char_to_pattern(input logic [7:0] c);
    logic [7:0] u;
    lut_t       r;
    u     = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    r.vld = 1'b1;
    r.pat = 8'h00;
    case (u)
      8'h20: r.pat = 8'b00000000;
      "A":   r.pat = 8'b00000110;
      "B":   r.pat = 8'b10010101;
      "C":   r.pat = 8'b10011001;
      "D":   r.pat = 8'b00100101;
      "E":   r.pat = 8'b00000001;
      "F":   r.pat = 8'b01011001;
      "G":   r.pat = 8'b00101001;
      "H":   r.pat = 8'b01010101;
      "I":   r.pat = 8'b00000101;
      "J":   r.pat = 8'b01101010;
      "K":   r.pat = 8'b00100110;
      "L":   r.pat = 8'b01100101;
      "M":   r.pat = 8'b00001010;
      "N":   r.pat = 8'b00001001;
      "O":   r.pat = 8'b00101010;
      "P":   r.pat = 8'b01101001;
      "Q":   r.pat = 8'b10100110;
      "R":   r.pat = 8'b00011001;
      "S":   r.pat = 8'b00010101;
      "T":   r.pat = 8'b00000010;
      "U":   r.pat = 8'b00010110;
      "V":   r.pat = 8'b01010110;
      "W":   r.pat = 8'b00011010;
      "X":   r.pat = 8'b10010110;
      "Y":   r.pat = 8'b10011010;
      "Z":   r.pat = 8'b10100101;
      default: r.vld = 1'b0;
    endcase
    return r;
  endfunction

  // Shift leading empty pairs out so the first symbol to send sits in [7:6].
  function automatic logic [7:0] normalize(input logic [7:0] p);
    logic [7:0] r;
    r = p;
    for (int i = 0; i < 3; i++) begin
      if (r[7:6] == SYM_NONE) r = {r[5:0], 2'b00};
    end
    return r;
  endfunction

endpackage

// File: rtl/morse_lut.sv
// ASCII-to-Morse pattern lookup with supported-character flag.
// Latency: combinational, zero cycles.
// No flow control; the caller samples the result at its own handshake.
module morse_lut
  import morse_pkg::*;
(
  input  logic [7:0] ch,
  output logic [7:0] pat,
  output logic       vld
);

  lut_t res;

  assign res = char_to_pattern(ch);
  assign pat = res.pat;
  assign vld = res.vld;

endmodule

// File: rtl/morse_encoder.sv
// Keys one ASCII character as Morse on key_out with unit-accurate marks and gaps.
// Latency: key_out rises the cycle after transfer; char_done in the last gap cycle.
// Backpressure: in_ready only in IDLE; in_valid outside IDLE is ignored, no queueing.
module morse_encoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_char,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       key_out,
  output logic       busy,
  output logic [7:0] morse_array,
  output logic       char_done,
  output logic       err
);

  localparam int CW = $clog2(4 * UNIT_CYCLES + 1);
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t LEN_1 = cnt_t'(UNIT_CYCLES);
  localparam cnt_t LEN_3 = cnt_t'(3 * UNIT_CYCLES);
  localparam cnt_t LEN_4 = cnt_t'(4 * UNIT_CYCLES);

  // Length of a state in cycles; a mark's length depends on the symbol being sent.
  function automatic cnt_t state_len(input state_t st, input logic [1:0] sym);
    case (st)
      ST_MARK:     return (sym == SYM_DASH) ? LEN_3 : LEN_1;
      ST_SYM_GAP:  return LEN_1;
      ST_CHAR_GAP: return LEN_3;
      ST_WORD_GAP: return LEN_4;
      default:     return cnt_t'(1);
    endcase
  endfunction

  logic [7:0] lut_pat;
  logic       lut_vld;

  morse_lut u_lut (
    .ch  (in_char),
    .pat (lut_pat),
    .vld (lut_vld)
  );

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [7:0] shr_q, shr_d;
  logic [7:0] arr_q, arr_d;
  logic       key_q, key_d;
  logic       busy_q, busy_d;
  logic       rdy_q, rdy_d;
  logic       err_q, err_d;
  logic       done_q, done_d;
  logic       last;

  // Next state, unit counter, symbol shifter and the registered output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + cnt_t'(1);
    shr_d   = shr_q;
    arr_d   = arr_q;
    last    = (cnt_q == state_len(state_q, shr_q[7:6]) - cnt_t'(1));
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (in_valid) begin
          if (!lut_vld) begin
            state_d = ST_ERR;
          end else if (lut_pat == 8'h00) begin
            state_d = ST_WORD_GAP;
            arr_d   = 8'h00;
          end else begin
            state_d = ST_MARK;
            arr_d   = lut_pat;
            shr_d   = normalize(lut_pat);
          end
        end
      end
      ST_MARK: begin
        if (last) begin
          shr_d   = {shr_q[5:0], 2'b00};
          state_d = (shr_q[5:4] != SYM_NONE) ? ST_SYM_GAP : ST_CHAR_GAP;
        end
      end
      ST_SYM_GAP: begin
        if (last) state_d = ST_MARK;
      end
      ST_CHAR_GAP, ST_WORD_GAP: begin
        if (last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Every state change restarts the unit count so no drift accumulates.
    if (state_d != state_q) cnt_d = '0;
    key_d  = (state_d == ST_MARK);
    busy_d = (state_d != ST_IDLE);
    rdy_d  = (state_d == ST_IDLE);
    err_d  = (state_d == ST_ERR);
    done_d = ((state_d == ST_CHAR_GAP) || (state_d == ST_WORD_GAP)) &&
             (cnt_d == state_len(state_d, shr_d[7:6]) - cnt_t'(1));
  end

  // Encoder FSM state and registered outputs; reset aborts any character in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shr_q   <= 8'h00;
      arr_q   <= 8'h00;
      key_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b1;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shr_q   <= shr_d;
      arr_q   <= arr_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign in_ready    = rdy_q;
  assign key_out     = key_q;
  assign busy        = busy_q;
  assign morse_array = arr_q;
  assign char_done   = done_q;
  assign err         = err_q;

endmodule
